// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   // Storage width for a destination index; any REG_W up to this fits.
   localparam int unsigned RW_MAX_W = 8;

   // Forwarding select: 0 selects the register file, k selects stage k.
   localparam int unsigned FWD_MAX_W = 3;
   typedef logic [FWD_MAX_W-1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_REG = '0;

   // Bit positions inside an NZVC nibble.
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_C = 0;

   // One in-flight instruction as tracked by the scoreboard.
   typedef struct packed {
      logic                valid;
      logic [RW_MAX_W-1:0] rw;
      logic                reg_write;
      logic                mem_read;
      logic                set_flags;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-side and EX-side signals exchanged between the pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned STAGES = 3,
   parameter int unsigned CNT_W  = 32
);
   localparam int unsigned FW = $clog2(STAGES + 1);

   logic             id_valid;
   logic [REG_W-1:0] id_ra;
   logic [REG_W-1:0] id_rb;
   logic             id_use_ra;
   logic             id_use_rb;
   logic [REG_W-1:0] id_rw;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             id_set_flags;
   logic             ex_br_taken;
   logic [3:0]       ex_flags;

   logic [FW-1:0]    fwd_a;
   logic [FW-1:0]    fwd_b;
   logic             stall;
   logic             flush;
   logic             ex_bubble;
   logic [3:0]       flags;
   logic [3:0]       flags_fwd;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline side: presents the ID instruction and EX resolution.
   modport master (
      output id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_rw,
             id_reg_write, id_mem_read, id_set_flags, ex_br_taken, ex_flags,
      input  fwd_a, fwd_b, stall, flush, ex_bubble, flags, flags_fwd,
             stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_rw,
             id_reg_write, id_mem_read, id_set_flags, ex_br_taken, ex_flags,
      output fwd_a, fwd_b, stall, flush, ex_bubble, flags, flags_fwd,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Shift register of in-flight writers with per-stage source match and data-ready flags.
module hazard_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned STAGES   = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  sb_entry_t         ins,
   input  logic [REG_W-1:0]  ra,
   input  logic [REG_W-1:0]  rb,
   input  logic              use_ra,
   input  logic              use_rb,
   output logic [STAGES:1]   match_a,
   output logic [STAGES:1]   match_b,
   output logic [STAGES:1]   ready,
   output logic              head_sets_flags
);

   sb_entry_t sb_q [1:STAGES];
   sb_entry_t sb_d [1:STAGES];

   logic ra_live;
   logic rb_live;

   // Next scoreboard: new instruction or bubble into stage 1, everything else moves down.
   always_comb begin
      sb_d[1] = capture ? ins : SB_EMPTY;
      if (ins.rw == RW_MAX_W'(ZERO_REG)) begin
         sb_d[1].reg_write = 1'b0;
      end
      for (int unsigned k = 2; k <= STAGES; k++) begin
         sb_d[k] = sb_q[k-1];
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk) begin
      for (int unsigned k = 1; k <= STAGES; k++) begin
         if (reset) begin
            sb_q[k] <= SB_EMPTY;
         end else begin
            sb_q[k] <= sb_d[k];
         end
      end
   end

   // Per-stage match against each used, non-zero source, and load readiness.
   always_comb begin
      ra_live = use_ra && (ra != REG_W'(ZERO_REG));
      rb_live = use_rb && (rb != REG_W'(ZERO_REG));
      match_a = '0;
      match_b = '0;
      ready   = '0;
      for (int unsigned k = 1; k <= STAGES; k++) begin
         match_a[k] = ra_live && sb_q[k].valid && sb_q[k].reg_write &&
                      (sb_q[k].rw == RW_MAX_W'(ra));
         match_b[k] = rb_live && sb_q[k].valid && sb_q[k].reg_write &&
                      (sb_q[k].rw == RW_MAX_W'(rb));
         ready[k]   = !sb_q[k].mem_read || (k > LOAD_LAT);
      end
   end

   assign head_sets_flags = sb_q[1].valid && sb_q[1].set_flags;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller top: forwarding priority, stall/flush arbitration, NZVC register, counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned STAGES   = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned ZERO_REG = 31,
   parameter int unsigned CNT_W    = 32
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned FW = $clog2(STAGES + 1);

   logic [STAGES:1] match_a;
   logic [STAGES:1] match_b;
   logic [STAGES:1] ready;
   logic            head_sets_flags;
   logic            capture;
   sb_entry_t       ins;

   logic [FW-1:0]    fwd_a_c;
   logic [FW-1:0]    fwd_b_c;
   logic             wait_src;
   logic             stall_c;
   logic             flush_c;

   logic [3:0]       flags_q;
   logic [3:0]       flags_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   // Scoreboard entry for the instruction currently in ID.
   always_comb begin
      ins           = SB_EMPTY;
      ins.valid     = 1'b1;
      ins.rw        = RW_MAX_W'(bus.id_rw);
      ins.reg_write = bus.id_reg_write;
      ins.mem_read  = bus.id_mem_read;
      ins.set_flags = bus.id_set_flags;
   end

   assign capture = bus.id_valid && !stall_c && !flush_c;

   hazard_scoreboard #(
      .REG_W    (REG_W),
      .STAGES   (STAGES),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk             (clk),
      .reset           (reset),
      .capture         (capture),
      .ins             (ins),
      .ra              (bus.id_ra),
      .rb              (bus.id_rb),
      .use_ra          (bus.id_use_ra),
      .use_rb          (bus.id_use_rb),
      .match_a         (match_a),
      .match_b         (match_b),
      .ready           (ready),
      .head_sets_flags (head_sets_flags)
   );

   // Nearest match wins; a nearest match that is not ready selects the regfile and relies on the stall.
   always_comb begin
      fwd_a_c  = FW'(FWD_REG);
      fwd_b_c  = FW'(FWD_REG);
      wait_src = 1'b0;
      for (int unsigned k = STAGES; k >= 1; k--) begin
         if (match_a[k]) begin
            fwd_a_c = ready[k] ? FW'(k) : FW'(FWD_REG);
         end
         if (match_b[k]) begin
            fwd_b_c = ready[k] ? FW'(k) : FW'(FWD_REG);
         end
         wait_src = wait_src || ((match_a[k] || match_b[k]) && !ready[k]);
      end
   end

   // A taken branch overrides any load-use stall; reset forces all outputs idle.
   always_comb begin
      flush_c = !reset && bus.ex_br_taken;
      stall_c = !reset && bus.id_valid && wait_src && !flush_c;
   end

   // Next-state for the flag register and the two event counters.
   always_comb begin
      flags_d     = head_sets_flags ? bus.ex_flags : flags_q;
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_c);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush_c);
   end

   // Architectural flags and performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         flags_q     <= flags_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.fwd_a     = reset ? FW'(FWD_REG) : fwd_a_c;
   assign bus.fwd_b     = reset ? FW'(FWD_REG) : fwd_b_c;
   assign bus.stall     = stall_c;
   assign bus.flush     = flush_c;
   assign bus.ex_bubble = stall_c || flush_c;
   assign bus.flags     = flags_q;
   assign bus.flags_fwd = reset ? 4'b0000 : flags_d;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   pipe_hazard_ctrl_if #(.REG_W(5), .STAGES(3), .CNT_W(32)) bus ();

   pipe_hazard_ctrl #(
      .REG_W    (5),
      .STAGES   (3),
      .LOAD_LAT (1),
      .ZERO_REG (31),
      .CNT_W    (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one ID instruction plus EX-side inputs.
   task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub, input logic [4:0] rw,
                        input logic we, input logic mr, input logic sf,
                        input logic br, input logic [3:0] exf);
      bus.id_valid     = v;
      bus.id_ra        = ra;
      bus.id_rb        = rb;
      bus.id_use_ra    = ua;
      bus.id_use_rb    = ub;
      bus.id_rw        = rw;
      bus.id_reg_write = we;
      bus.id_mem_read  = mr;
      bus.id_set_flags = sf;
      bus.ex_br_taken  = br;
      bus.ex_flags     = exf;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
      step();
      step();

      check("rst_fwd_a", 32'(bus.fwd_a), 0);
      check("rst_fwd_b", 32'(bus.fwd_b), 0);
      check("rst_stall", 32'(bus.stall), 0);
      check("rst_flush", 32'(bus.flush), 0);
      check("rst_bubble", 32'(bus.ex_bubble), 0);
      check("rst_flags", 32'(bus.flags), 0);
      check("rst_flags_fwd", 32'(bus.flags_fwd), 0);
      check("rst_stall_cnt", bus.stall_cnt, 0);
      check("rst_flush_cnt", bus.flush_cnt, 0);

      reset = 1'b0;
      // ADD X1, X3, X4
      drive(1, 3, 4, 1, 1, 1, 1, 0, 0, 0, 4'h0);
      check("add_fwd_a", 32'(bus.fwd_a), 0);
      step();
      // SUB X5, X1, X6 -> forward from EX
      drive(1, 1, 6, 1, 1, 5, 1, 0, 0, 0, 4'h0);
      check("b2b_fwd_a1", 32'(bus.fwd_a), 1);
      check("b2b_stall", 32'(bus.stall), 0);
      step();
      // ORR X7, X1, X8 -> forward from MEM
      drive(1, 1, 8, 1, 1, 7, 1, 0, 0, 0, 4'h0);
      check("b2b_fwd_a2", 32'(bus.fwd_a), 2);
      check("b2b_fwd_b0", 32'(bus.fwd_b), 0);
      check("b2b_stall2", 32'(bus.stall), 0);
      step();
      // LDUR X2, [X9]
      drive(1, 9, 0, 1, 0, 2, 1, 1, 0, 0, 4'h0);
      check("ld_fwd_a", 32'(bus.fwd_a), 0);
      step();
      // ADD X10, X11, X2 -> one-cycle load-use stall
      drive(1, 11, 2, 1, 1, 10, 1, 0, 0, 0, 4'h0);
      check("lu_stall", 32'(bus.stall), 1);
      check("lu_bubble", 32'(bus.ex_bubble), 1);
      check("lu_fwd_b", 32'(bus.fwd_b), 0);
      step();
      check("lu_stall_after", 32'(bus.stall), 0);
      check("lu_bubble_after", 32'(bus.ex_bubble), 0);
      check("lu_fwd_b_after", 32'(bus.fwd_b), 2);
      check("lu_stall_cnt", bus.stall_cnt, 1);
      step();
      // ADD X31, X12, X13 (write to zero register)
      drive(1, 12, 13, 1, 1, 31, 1, 0, 0, 0, 4'h0);
      check("zr_writer_stall", 32'(bus.stall), 0);
      step();
      // reader of X31 and X10
      drive(1, 31, 10, 1, 1, 0, 0, 0, 0, 0, 4'h0);
      check("zr_fwd_a", 32'(bus.fwd_a), 0);
      check("zr_stall", 32'(bus.stall), 0);
      check("zr_fwd_b", 32'(bus.fwd_b), 2);
      step();
      // LDUR X14, [X15]
      drive(1, 15, 0, 1, 0, 14, 1, 1, 0, 0, 4'h0);
      step();
      // SUBS X16, X14 with branch taken in EX
      drive(1, 14, 0, 1, 0, 16, 1, 0, 1, 1, 4'h0);
      check("fl_flush", 32'(bus.flush), 1);
      check("fl_stall", 32'(bus.stall), 0);
      check("fl_bubble", 32'(bus.ex_bubble), 1);
      check("fl_cnt_before", bus.flush_cnt, 0);
      step();
      // flushed SUBS must be absent: no forward of X16, no flag update
      drive(1, 16, 14, 1, 1, 17, 1, 0, 0, 0, 4'hF);
      check("fl_fwd_a", 32'(bus.fwd_a), 0);
      check("fl_fwd_b", 32'(bus.fwd_b), 2);
      check("fl_stall_after", 32'(bus.stall), 0);
      check("fl_flush_after", 32'(bus.flush), 0);
      check("fl_cnt", bus.flush_cnt, 1);
      check("fl_flags_fwd", 32'(bus.flags_fwd), 0);
      step();
      // SUBS X18, X19, X20
      drive(1, 19, 20, 1, 1, 18, 1, 0, 1, 0, 4'h0);
      check("fl_flags", 32'(bus.flags), 0);
      step();
      // SUBS in EX produces Z
      drive(1, 0, 0, 0, 0, 21, 1, 0, 0, 0, 4'b0100);
      check("fg_fwd_same", 32'(bus.flags_fwd), 32'b0100);
      check("fg_flags_before", 32'(bus.flags), 0);
      step();
      // non-setting ADD in EX with N asserted
      drive(1, 0, 0, 0, 0, 22, 1, 0, 0, 0, 4'b1000);
      check("fg_flags_next", 32'(bus.flags), 32'b0100);
      check("fg_fwd_hold", 32'(bus.flags_fwd), 32'b0100);
      step();
      // LDUR X23
      drive(1, 0, 0, 0, 0, 23, 1, 1, 0, 0, 4'b1000);
      check("fg_flags_hold", 32'(bus.flags), 32'b0100);
      step();
      // invalid ID slot reading X23 must not stall
      drive(0, 23, 23, 1, 1, 0, 0, 0, 0, 0, 4'h0);
      check("inv_stall", 32'(bus.stall), 0);
      check("inv_bubble", 32'(bus.ex_bubble), 0);
      step();
      // LDUR X24, then dependent reader
      drive(1, 0, 0, 0, 0, 24, 1, 1, 0, 0, 4'h0);
      step();
      drive(1, 24, 0, 1, 0, 25, 1, 0, 0, 0, 4'h0);
      check("rs_stall_pre", 32'(bus.stall), 1);
      reset = 1'b1;
      #1;
      check("rs_stall_now", 32'(bus.stall), 0);
      check("rs_bubble_now", 32'(bus.ex_bubble), 0);
      check("rs_fwd_fwd_now", 32'(bus.flags_fwd), 0);
      step();
      reset = 1'b0;
      #1;
      check("rs_fwd_a", 32'(bus.fwd_a), 0);
      check("rs_stall", 32'(bus.stall), 0);
      check("rs_flags", 32'(bus.flags), 0);
      check("rs_stall_cnt", bus.stall_cnt, 0);
      check("rs_flush_cnt", bus.flush_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case the stimulus process ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the ARM pipelined CPU. It replaces the hard-wired two-stage forwarding and fixed delay-slot handling with a registered scoreboard of in-flight writers over `STAGES` downstream stages. From that scoreboard it produces:
- N-way forwarding selects;
- load-use interlock stalls;
- branch-taken flushes;
- an architectural NZVC flag register that updates only on flag-setting instructions.

It sits beside the ID stage and observes EX resolution.

## Interface
Parameters:
- `REG_W`, 5: register index width.
- `STAGES`, 3: tracked stages after ID (1 = EX, 2 = MEM, 3 = WB); range 2..6.
- `LOAD_LAT`, 1: stages after EX before load data is forwardable (1..`STAGES`-1).
- `ZERO_REG`, 31: hardwired-zero register, never hazarded or forwarded.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk` in 1: clock; one clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_ra` in `REG_W`: first source index.
- `id_rb` in `REG_W`: second source index (post Reg2Loc mux).
- `id_use_ra` in 1: first source is read.
- `id_use_rb` in 1: second source is read.
- `id_rw` in `REG_W`: destination index.
- `id_reg_write` in 1: instruction writes `id_rw`.
- `id_mem_read` in 1: instruction is a load.
- `id_set_flags` in 1: ADDS/SUBS-class instruction.
- `ex_br_taken` in 1: branch in EX resolved taken this cycle.
- `ex_flags` in 4: NZVC from ALU, for the instruction in EX.
- `fwd_a` out `$clog2(STAGES+1)`: 0 = regfile, k = stage k result.
- `fwd_b` out `$clog2(STAGES+1)`: same encoding for the second source.
- `stall` out 1: hold PC and IF/ID register.
- `flush` out 1: squash IF/ID contents.
- `ex_bubble` out 1: ID/EX loads a NOP this cycle.
- `flags` out 4: architectural NZVC.
- `flags_fwd` out 4: NZVC as seen by an instruction in ID (bypassed).
- `stall_cnt` out `CNT_W`: cycles with `stall`=1.
- `flush_cnt` out `CNT_W`: cycles with `flush`=1.

## Operation
Scoreboard:
- Entry k (1..`STAGES`) holds {valid, rw, reg_write, mem_read, set_flags}.
- Each posedge, entries shift k→k+1 and entry `STAGES` is dropped.
- Entry 1 loads the ID instruction when `id_valid & ~stall & ~flush`; otherwise it loads an invalid entry (bubble).
- An entry with rw = `ZERO_REG` has reg_write forced to 0 on capture.

Source match:
- Entry k matches source s when it is valid, has reg_write set, rw == s, the source is used, and s != `ZERO_REG`.

Forwarding:
- `fwd_x` = smallest matching k whose data is ready.
- Ready means: not mem_read, or k > `LOAD_LAT`.
- `fwd_x` = 0 if there is no ready match.
- A nearer non-ready match forces a stall rather than forwarding from an older stage.

Load-use:
- `stall` = `id_valid` and any source matches an entry with k ≤ `LOAD_LAT` and mem_read=1.
- While stalled, `ex_bubble`=1.

Branch:
- `ex_br_taken`=1 asserts `flush` and `ex_bubble`, and forces `stall`=0, in that same cycle.
- Flush priority over stall is mandatory.

Flags:
- At posedge, `flags` ← `ex_flags` iff entry 1 is valid with set_flags=1.
- `flags_fwd` = `ex_flags` when entry 1 is valid and set_flags=1, else `flags`.

Counters:
- Each counter increments by 1 per qualifying cycle and wraps at 2^`CNT_W`.

## Timing
- Reset values: all scoreboard entries invalid; `flags`=0; `flags_fwd`=0; counters 0; `fwd_a`/`fwd_b`=0; `stall`=`flush`=`ex_bubble`=0.
- All outputs except `flags` and the counters are combinational from inputs plus the scoreboard, so they are valid in the same cycle as the ID inputs.
- A load followed by a dependent instruction stalls exactly `LOAD_LAT` cycles. After that the dependent instruction forwards from stage `LOAD_LAT`+1.
- Flag update appears on `flags` one cycle after the setting instruction is in EX.
- A flushed instruction never enters the scoreboard and never updates flags.
- `reset` asserted mid-stall or mid-flush clears all state at the next posedge; outputs return to reset values in that same cycle.
- `id_valid`=0 produces no stall, regardless of the source fields.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - `sb_entry_t` struct;
  - `fwd_sel_t` encoding constants (`FWD_REG`=0);
  - NZVC bit indices (N=3, Z=2, V=1, C=0).
- Sub-module `hazard_scoreboard` holds the `STAGES`-deep shift register and per-entry match/ready outputs.
- The top level performs priority encoding, stall/flush arbitration, the flag register and the counters.

## Test plan
- **Back-to-back ALU writes:** ADD X1 at t, then SUB using X1 at t+1 → `fwd_a`=1. The same X1 read at t+2 → `fwd_a`=2, with no stall.
- **Load-use, `LOAD_LAT`=1:** LDUR X2 followed by ADD reading X2 → `stall`=1 and `ex_bubble`=1 for exactly 1 cycle, then `fwd_b`=2; `stall_cnt`=1.
- **Zero register:** writer with rw=31 followed by a reader of X31 → `fwd_a`=0 and `stall`=0.
- **Flush beats stall:** `ex_br_taken`=1 in the same cycle as a load-use condition → `flush`=1, `stall`=0; the next cycle's entry 1 is invalid; `flush_cnt`=1.
- **Flag update:** SUBS with `ex_flags`=4'b0100 → `flags_fwd`=4'b0100 in the same cycle and `flags`=4'b0100 next cycle. A following ADD (set_flags=0) with `ex_flags`=4'b1000 leaves `flags` at 4'b0100.
- **Reset mid-operation:** `reset` asserted during a stall → the next cycle has all outputs at reset values and the scoreboard empty, so a dependent reader sees `fwd_a`=0.
